// File: rtl/user_la_value_port.sv
// LA-bus controlled 16-bit value register with 2-bit status, driven onto user pads.
// Optional macro LA_READBACK_EN registers value/status/strobe back onto la_data_out.
module user_la_value_port #(
    parameter int IO_BASE    = 20,
    parameter int STROBE_BIT = 18
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_OVERFLOW = 2'b01;
    localparam logic [1:0] ST_BAD_DIR  = 2'b10;

    logic [15:0] value;
    logic [1:0]  status;
    logic        strobe_q;

    logic        strobe;
    logic        fire;
    logic        dir_ok;
    logic [15:0] operand;
    logic [1:0]  opcode;
    logic [15:0] value_next;
    logic [1:0]  status_next;

    logic unused_inputs;
    assign unused_inputs = ^{io_in, la_data_in, la_oenb};

    assign strobe  = la_data_in[STROBE_BIT];
    assign fire    = strobe & ~strobe_q;
    assign dir_ok  = (la_oenb[STROBE_BIT:0] == '0);
    assign operand = la_data_in[15:0];
    assign opcode  = la_data_in[17:16];

    always_comb begin
        value_next  = value;
        status_next = status;
        if (fire) begin
            if (!dir_ok) begin
                status_next = ST_BAD_DIR;
            end else begin
                unique case (opcode)
                    OP_LOAD: begin
                        value_next  = operand;
                        status_next = ST_OK;
                    end
                    OP_INC: begin
                        value_next  = value + 16'd1;
                        status_next = (value == 16'hFFFF) ? ST_OVERFLOW : ST_OK;
                    end
                    OP_DEC: begin
                        value_next  = value - 16'd1;
                        status_next = (value == 16'h0000) ? ST_OVERFLOW : ST_OK;
                    end
                    OP_CLEAR: begin
                        value_next  = 16'h0000;
                        status_next = ST_OK;
                    end
                    default: begin
                        value_next  = value;
                        status_next = status;
                    end
                endcase
            end
        end
    end

    // Reset has priority, so a strobe landing on a reset edge is dropped.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            value    <= 16'h0000;
            status   <= ST_OK;
            strobe_q <= 1'b0;
        end else begin
            value    <= value_next;
            status   <= status_next;
            strobe_q <= strobe;
        end
    end

    always_comb begin
        io_out                     = '0;
        io_out[IO_BASE +: 16]      = value;
        io_out[IO_BASE + 16 +: 2]  = status;
        io_oeb                     = '1;
        io_oeb[IO_BASE +: 18]      = '0;
    end

`ifdef LA_READBACK_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            la_data_out <= '0;
        end else begin
            la_data_out <= {109'd0, strobe_q, status, value};
        end
    end
`else
    assign la_data_out = '0;
`endif

endmodule

// File: tb/tb_user_la_value_port.sv
// Directed self-checking bench for user_la_value_port; readback checks follow LA_READBACK_EN.
module tb_user_la_value_port;

    logic         wb_clk_i;
    logic         wb_rst_i;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    int tests_run;
    int tests_failed;

    localparam logic [37:0] OEB_EXP = {18'd0, 20'hFFFFF};

    user_la_value_port dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] operand, input logic strobe);
        la_data_in         = '0;
        la_data_in[15:0]   = operand;
        la_data_in[17:16]  = op;
        la_data_in[18]     = strobe;
    endtask

    // One clean command: strobe rises for one edge, then falls for one edge.
    task automatic command(input logic [1:0] op, input logic [15:0] operand);
        drive(op, operand, 1'b1);
        tick();
        drive(op, operand, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        wb_rst_i   = 1'b1;
        la_data_in = '0;
        la_oenb    = '0;
        io_in      = '0;
        tick();
        tick();
        tests_run++;
        if (io_out !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_io_out: got %h want %h", io_out, 38'd0);
        end
        tests_run++;
        if (io_oeb !== OEB_EXP) begin
            tests_failed++;
            $display("FAIL reset_io_oeb: got %h want %h", io_oeb, OEB_EXP);
        end
        tests_run++;
        if (la_data_out !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_la_data_out: got %h want 0", la_data_out);
        end
        wb_rst_i = 1'b0;
        tick();
    endtask

    task automatic test_load();
        command(2'b00, 16'd255);
        tests_run++;
        if (io_out[35:20] !== 16'd255 || io_out[37:36] !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_255: got value %h status %b want 00ff 00", io_out[35:20], io_out[37:36]);
        end
        tests_run++;
        if (io_oeb !== OEB_EXP || io_out[19:0] !== 20'd0) begin
            tests_failed++;
            $display("FAIL load_255_pads: got oeb %h low %h want %h 0", io_oeb, io_out[19:0], OEB_EXP);
        end
    endtask

    task automatic test_strobe_hold();
        drive(2'b00, 16'd1, 1'b1);
        tick();
        tests_run++;
        if (io_out[35:20] !== 16'd1 || io_out[37:36] !== 2'b00) begin
            tests_failed++;
            $display("FAIL hold_first_fire: got value %h status %b want 0001 00", io_out[35:20], io_out[37:36]);
        end
        // Keep strobe high while changing the command; nothing may refire.
        drive(2'b01, 16'h7777, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (io_out[35:20] !== 16'd1 || io_out[37:36] !== 2'b00) begin
            tests_failed++;
            $display("FAIL hold_no_repeat: got value %h status %b want 0001 00", io_out[35:20], io_out[37:36]);
        end
        drive(2'b00, 16'd0, 1'b0);
        tick();
    endtask

    task automatic test_arith();
        command(2'b00, 16'd5);
        command(2'b01, 16'd0);
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd6}) begin
            tests_failed++;
            $display("FAIL inc_plain: got %h want %h", io_out[37:20], {2'b00, 16'd6});
        end
        command(2'b10, 16'd0);
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd5}) begin
            tests_failed++;
            $display("FAIL dec_plain: got %h want %h", io_out[37:20], {2'b00, 16'd5});
        end
    endtask

    task automatic test_wrap();
        command(2'b00, 16'hFFFF);
        command(2'b01, 16'd0);
        tests_run++;
        if (io_out[37:20] !== {2'b01, 16'h0000}) begin
            tests_failed++;
            $display("FAIL inc_wrap: got %h want %h", io_out[37:20], {2'b01, 16'h0000});
        end
        command(2'b10, 16'd0);
        tests_run++;
        if (io_out[37:20] !== {2'b01, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL dec_wrap: got %h want %h", io_out[37:20], {2'b01, 16'hFFFF});
        end
        command(2'b11, 16'hABCD);
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'h0000}) begin
            tests_failed++;
            $display("FAIL clear: got %h want %h", io_out[37:20], {2'b00, 16'h0000});
        end
    endtask

    task automatic test_invalid_dir();
        command(2'b00, 16'd5);
        la_oenb    = '0;
        la_oenb[3] = 1'b1;
        command(2'b00, 16'h1234);
        tests_run++;
        if (io_out[37:20] !== {2'b10, 16'd5}) begin
            tests_failed++;
            $display("FAIL bad_dir_bit3: got %h want %h", io_out[37:20], {2'b10, 16'd5});
        end
        la_oenb     = '0;
        la_oenb[18] = 1'b1;
        command(2'b11, 16'd0);
        tests_run++;
        if (io_out[37:20] !== {2'b10, 16'd5}) begin
            tests_failed++;
            $display("FAIL bad_dir_bit18: got %h want %h", io_out[37:20], {2'b10, 16'd5});
        end
        // Bits above the strobe do not take part in the direction check.
        la_oenb     = '0;
        la_oenb[40] = 1'b1;
        command(2'b00, 16'd9);
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd9}) begin
            tests_failed++;
            $display("FAIL dir_high_bits_ok: got %h want %h", io_out[37:20], {2'b00, 16'd9});
        end
        la_oenb = '0;
        command(2'b00, 16'd5);
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd5}) begin
            tests_failed++;
            $display("FAIL recover_load5: got %h want %h", io_out[37:20], {2'b00, 16'd5});
        end
    endtask

    task automatic test_reset_collision();
        command(2'b00, 16'd7);
        drive(2'b01, 16'd0, 1'b1);
        wb_rst_i = 1'b1;
        tick();
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_wins: got %h want %h", io_out[37:20], {2'b00, 16'd0});
        end
        // Strobe stays high across release: exactly one INC afterwards.
        wb_rst_i = 1'b0;
        tick();
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd1}) begin
            tests_failed++;
            $display("FAIL post_reset_fire: got %h want %h", io_out[37:20], {2'b00, 16'd1});
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (io_out[37:20] !== {2'b00, 16'd1}) begin
            tests_failed++;
            $display("FAIL post_reset_once: got %h want %h", io_out[37:20], {2'b00, 16'd1});
        end
        drive(2'b00, 16'd0, 1'b0);
        tick();
    endtask

    task automatic test_readback();
        drive(2'b00, 16'hA5A5, 1'b1);
        tick();
        tests_run++;
        if (io_out[35:20] !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL rb_value: got %h want a5a5", io_out[35:20]);
        end
`ifdef LA_READBACK_EN
        tests_run++;
        if (la_data_out[17:0] !== {2'b00, 16'd1}) begin
            tests_failed++;
            $display("FAIL rb_lag: got %h want %h", la_data_out[17:0], {2'b00, 16'd1});
        end
`endif
        drive(2'b00, 16'hA5A5, 1'b0);
        tick();
`ifdef LA_READBACK_EN
        tests_run++;
        if (la_data_out[17:0] !== {2'b00, 16'hA5A5} || la_data_out[127:19] !== '0) begin
            tests_failed++;
            $display("FAIL rb_a5a5: got %h want %h", la_data_out, {2'b00, 16'hA5A5});
        end
`else
        tests_run++;
        if (la_data_out !== 128'd0) begin
            tests_failed++;
            $display("FAIL rb_tied_zero: got %h want 0", la_data_out);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_load();
        test_strobe_hold();
        test_arith();
        test_wrap();
        test_invalid_dir();
        test_reset_collision();
        test_readback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
